// File: rtl/mash111_div_ctrl.sv
// mash111_div_ctrl: third-order MASH 1-1-1 fractional-N modulus controller for the feedback divider.
// Latency: div_ratio/delta registered one divider cycle after the state that produced them; a config
//   transfer at edge k becomes active at edge k+1, and the first ratio built from it appears after k+2.
// Backpressure: cfg_ready = !pending, so one config is accepted at most every 2 cycles; cfg_valid is ignored while not ready.
// Ports:
//   clk, rst          divided-feedback clock (one edge per divider cycle), async active-high reset
//   en                modulator enable (low = integer-N, accumulators hold)
//   cfg_valid/ready   config handshake for n_int (INT_W) / n_frac (ACC_W)
//   div_ratio         registered ratio for the next divider cycle (INT_W+1 bits)
//   delta             registered correction; 3'b100 means +4 (the code -4 never occurs)
//   cfg_applied       one-cycle pulse when the shadow config becomes active
//   range_err         sticky, set whenever div_ratio had to be clamped
module mash111_div_ctrl #(
  parameter int ACC_W   = 16,
  parameter int INT_W   = 8,
  parameter int MIN_DIV = 4,
  parameter int RESET_N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [INT_W-1:0] n_int,
  input  logic [ACC_W-1:0] n_frac,
  output logic [INT_W:0]   div_ratio,
  output logic [2:0]       delta,
  output logic             cfg_applied,
  output logic             range_err
);

  localparam logic signed [INT_W+2:0] LP_LO = (INT_W+3)'(MIN_DIV);
  localparam logic signed [INT_W+2:0] LP_HI = (INT_W+3)'((2**(INT_W+1)) - 1);

  logic [ACC_W-1:0] r_acc1, r_acc2, r_acc3;
  logic             r_c2_d, r_c3_d, r_c3_dd;
  logic [INT_W-1:0] r_n, r_sh_n;
  logic [ACC_W-1:0] r_f, r_sh_f;
  logic             r_pending;
  logic [INT_W:0]   r_div_ratio;
  logic [2:0]       r_delta;
  logic             r_cfg_applied;
  logic             r_range_err;

  logic [ACC_W:0]          w_s1, w_s2, w_s3;
  logic [3:0]              w_d;
  logic [3:0]              w_dsel;
  logic signed [INT_W+2:0] w_sum;
  logic [INT_W:0]          w_ratio;
  logic                    w_clamp;

  // Cascaded accumulators; bit ACC_W of each sum is the stage carry.
  assign w_s1 = {1'b0, r_acc1} + {1'b0, r_f};
  assign w_s2 = {1'b0, r_acc2} + {1'b0, w_s1[ACC_W-1:0]};
  assign w_s3 = {1'b0, r_acc3} + {1'b0, w_s2[ACC_W-1:0]};

  // Noise-cancellation network c1 + (1-z^-1)c2 + (1-z^-1)^2 c3, done modulo 16 so the
  // 4-bit result is directly the two's-complement correction (-3..+4).
  assign w_d = {3'b000, w_s1[ACC_W]}
             + {3'b000, w_s2[ACC_W]} - {3'b000, r_c2_d}
             + {3'b000, w_s3[ACC_W]} - {2'b00, r_c3_d, 1'b0} + {3'b000, r_c3_dd};

  assign w_dsel = en ? w_d : 4'd0;

  // Widened signed sum so both clamp bounds are comparable without wrap.
  assign w_sum = $signed({3'b000, r_n}) + $signed({{(INT_W-1){w_dsel[3]}}, w_dsel});

  always_comb begin
    w_ratio = w_sum[INT_W:0];
    w_clamp = 1'b0;
    if (w_sum < LP_LO) begin
      w_ratio = (INT_W+1)'(MIN_DIV);
      w_clamp = 1'b1;
    end else if (w_sum > LP_HI) begin
      w_ratio = '1;
      w_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc1        <= '0;
      r_acc2        <= '0;
      r_acc3        <= '0;
      r_c2_d        <= 1'b0;
      r_c3_d        <= 1'b0;
      r_c3_dd       <= 1'b0;
      r_n           <= INT_W'(RESET_N);
      r_f           <= '0;
      r_sh_n        <= '0;
      r_sh_f        <= '0;
      r_pending     <= 1'b0;
      r_div_ratio   <= (INT_W+1)'(RESET_N);
      r_delta       <= 3'd0;
      r_cfg_applied <= 1'b0;
      r_range_err   <= 1'b0;
    end else begin
      if (en) begin
        r_acc1  <= w_s1[ACC_W-1:0];
        r_acc2  <= w_s2[ACC_W-1:0];
        r_acc3  <= w_s3[ACC_W-1:0];
        r_c2_d  <= w_s2[ACC_W];
        r_c3_dd <= r_c3_d;
        r_c3_d  <= w_s3[ACC_W];
      end
      r_delta     <= w_dsel[2:0];
      r_div_ratio <= w_ratio;
      if (w_clamp) begin
        r_range_err <= 1'b1;
      end
      // Apply edge takes priority; ready is low then, so no transfer can collide with it.
      // Accumulators are left alone so the modulator phase stays continuous across updates.
      if (r_pending) begin
        r_n           <= r_sh_n;
        r_f           <= r_sh_f;
        r_pending     <= 1'b0;
        r_cfg_applied <= 1'b1;
      end else begin
        r_cfg_applied <= 1'b0;
        if (cfg_valid) begin
          r_sh_n    <= n_int;
          r_sh_f    <= n_frac;
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready   = !r_pending;
  assign div_ratio   = r_div_ratio;
  assign delta       = r_delta;
  assign cfg_applied = r_cfg_applied;
  assign range_err   = r_range_err;

endmodule

// File: tb/tb_mash111_div_ctrl.sv
// tb_mash111_div_ctrl: scoreboard bench for mash111_div_ctrl with an integer-arithmetic reference model.
// Latency: each stimulus edge pushes one expected output set, popped and compared on the following negedge.
// Backpressure: the model tracks the pending config itself; the bench offers configs regardless of ready.
module tb_mash111_div_ctrl;

  typedef struct packed {
    logic [8:0] ratio;
    logic [2:0] delta;
    logic       rdy;
    logic       app;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] n_int = 8'd0;
  logic [15:0] n_frac = 16'd0;
  logic [8:0] div_ratio;
  logic [2:0] delta;
  logic       cfg_applied;
  logic       range_err;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  bit sum_en = 1'b0;
  int dsum = 0;

  // Reference model state, plain integers.
  int m_a1, m_a2, m_a3, m_c2d, m_c3d, m_c3dd;
  int m_n, m_f, m_shn, m_shf, m_pend, m_err;

  mash111_div_ctrl #(.ACC_W(16), .INT_W(8), .MIN_DIV(4), .RESET_N(32)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .n_int(n_int), .n_frac(n_frac), .div_ratio(div_ratio), .delta(delta),
    .cfg_applied(cfg_applied), .range_err(range_err)
  );

  always #5 clk = ~clk;

  function automatic int dec(input logic [2:0] v);
    if (v == 3'b100) return 4;
    if (v[2]) return int'(v) - 8;
    return int'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a new output set every edge; compare it away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("div_ratio", int'(div_ratio), int'(e.ratio));
        check("delta", dec(delta), dec(e.delta));
        check("cfg_ready", int'(cfg_ready), int'(e.rdy));
        check("cfg_applied", int'(cfg_applied), int'(e.app));
        check("range_err", int'(range_err), int'(e.err));
        if (sum_en) dsum += dec(delta);
      end
    end
  end

  task automatic model_reset();
    m_a1 = 0; m_a2 = 0; m_a3 = 0; m_c2d = 0; m_c3d = 0; m_c3dd = 0;
    m_n = 32; m_f = 0; m_shn = 0; m_shf = 0; m_pend = 0; m_err = 0;
  endtask

  // Drive one edge worth of inputs, predict the outputs after that edge, queue them.
  task automatic step(input bit e_en, input bit cv, input int ni, input int nf);
    int s1, s2, s3, c1, c2, c3, d, r, app;
    exp_t x;
    en = e_en;
    cfg_valid = cv;
    n_int = 8'(ni);
    n_frac = 16'(nf);
    d = 0;
    if (e_en) begin
      s1 = m_a1 + m_f; c1 = s1 / 65536; s1 = s1 % 65536;
      s2 = m_a2 + s1;  c2 = s2 / 65536; s2 = s2 % 65536;
      s3 = m_a3 + s2;  c3 = s3 / 65536; s3 = s3 % 65536;
      d = c1 + (c2 - m_c2d) + (c3 - 2 * m_c3d + m_c3dd);
      m_a1 = s1; m_a2 = s2; m_a3 = s3;
      m_c2d = c2; m_c3dd = m_c3d; m_c3d = c3;
    end
    r = m_n + d;
    if (r < 4) begin
      r = 4; m_err = 1;
    end else if (r > 511) begin
      r = 511; m_err = 1;
    end
    if (m_pend != 0) begin
      m_n = m_shn; m_f = m_shf; m_pend = 0; app = 1;
    end else begin
      app = 0;
      if (cv) begin
        m_shn = ni % 256; m_shf = nf & 65535; m_pend = 1;
      end
    end
    x.ratio = 9'(r);
    x.delta = 3'(d);
    x.rdy = (m_pend == 0);
    x.app = (app != 0);
    x.err = (m_err != 0);
    @(posedge clk);
    exp_q.push_back(x);
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  // Reset lands between edges; outputs must take reset values before any clock edge.
  task automatic do_reset();
    drain();
    rst = 1'b1;
    #1;
    check("rst div_ratio", int'(div_ratio), 32);
    check("rst delta", dec(delta), 0);
    check("rst cfg_ready", int'(cfg_ready), 1);
    check("rst cfg_applied", int'(cfg_applied), 0);
    check("rst range_err", int'(range_err), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int tbl[4];
    tbl[0] = 0; tbl[1] = 2; tbl[2] = -1; tbl[3] = 1;
    model_reset();
    do_reset();

    // Integer mode: ratio 40 held constant.
    step(1'b1, 1'b1, 40, 0);
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 40, 0);

    // Reset mid-run with en=1.
    en = 1'b1;
    do_reset();

    // Half fraction from zero accumulators: fixed 4-cycle pattern.
    step(1'b0, 1'b1, 32, 16'h8000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32, 0);
      check("half delta", dec(delta), tbl[i % 4]);
      check("half div_ratio", int'(div_ratio), 32 + tbl[i % 4]);
    end

    // Mean accuracy over one full accumulator period.
    do_reset();
    step(1'b0, 1'b1, 32, 16'h1234);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32, 0);
    drain();
    dsum = 0;
    sum_en = 1'b1;
    for (int i = 0; i < 65536; i++) step(1'b1, 1'b0, 32, 0);
    drain();
    sum_en = 1'b0;
    checks++;
    if (dsum < 16'h1234 - 3 || dsum > 16'h1234 + 3) begin
      errors++;
      $display("FAIL delta sum: got %0d expected %0d +/-3", dsum, 16'h1234);
    end

    // Handshake: valid held high with a changing config.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, $urandom_range(20, 200), $urandom);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 0);

    // Saturation at MIN_DIV.
    do_reset();
    step(1'b1, 1'b1, 4, 16'h8000);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 0, 0);
    check("sat range_err set", int'(range_err), 1);
    step(1'b1, 1'b1, 100, 0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 0);
    check("sat range_err sticky", int'(range_err), 1);
    do_reset();

    // Random mix of enable, configs, low ratios and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int ni;
      ni = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 255);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ni, $urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    drain();
    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
